// File: rtl/reu_dma_pkg.sv
// Shared definitions for the REU-style DMA initiator: state encoding, direction codes, defaults.
package reu_dma_pkg;

   localparam int unsigned RAMA_W_DEF     = 22;
   localparam int unsigned LEN_W_DEF      = 16;
   localparam int unsigned SETTLE_CYC_DEF = 3;
   localparam int unsigned SETTLE_W       = 8;

   localparam logic DIR_STASH = 1'b0;
   localparam logic DIR_FETCH = 1'b1;

   // BUSH is the single C8M hold cycle after the bus-cycle PHI2 falling edge
   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_ACQ  = 4'd1,
      ST_PREF = 4'd2,
      ST_BUSW = 4'd3,
      ST_BUSC = 4'd4,
      ST_BUSH = 4'd5,
      ST_RAMW = 4'd6,
      ST_NEXT = 4'd7,
      ST_REL  = 4'd8
   } state_t;

   // Bus is held (nDMA low, busy high) in every state except IDLE and REL
   function automatic logic is_busy_state(input state_t s);
      return (s != ST_IDLE) && (s != ST_REL);
   endfunction

endpackage

// File: rtl/reu_dma_phi2_sync.sv
// Brings PHI2 and BA into the C8M domain and produces 1-cycle PHI2 edge pulses.
module reu_dma_phi2_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_phi2,
   input  logic i_ba,
   output logic o_phr,
   output logic o_phf,
   output logic o_ba
);

   logic [2:0] r_phi2_sh;
   logic [1:0] r_ba_sh;
   logic       r_phr;
   logic       r_phf;

   // Two-flop synchronizers plus one history flop for PHI2 edge detection
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_phi2_sh <= 3'b000;
         r_ba_sh   <= 2'b00;
         r_phr     <= 1'b0;
         r_phf     <= 1'b0;
      end else begin
         r_phi2_sh <= {r_phi2_sh[1:0], i_phi2};
         r_ba_sh   <= {r_ba_sh[0], i_ba};
         r_phr     <= r_phi2_sh[1] & ~r_phi2_sh[2];
         r_phf     <= ~r_phi2_sh[1] & r_phi2_sh[2];
      end
   end

   assign o_phr = r_phr;
   assign o_phf = r_phf;
   assign o_ba  = r_ba_sh[1];

endmodule

// File: rtl/reu_dma.sv
// C64 expansion-port bus-master DMA: moves len bytes between C64 memory and expansion RAM.
module reu_dma
   import reu_dma_pkg::*;
#(
   parameter int unsigned RAMA_W     = RAMA_W_DEF,
   parameter int unsigned LEN_W      = LEN_W_DEF,
   parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
   input  logic              C8M,
   input  logic              RESET,
   input  logic              PHI2,
   input  logic              BA,
   input  logic              start,
   input  logic              dir,
   input  logic [15:0]       c64_addr,
   input  logic [RAMA_W-1:0] ram_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic              nDMA,
   output logic              nWEDMA,
   output logic [15:0]       A_out,
   output logic              A_oe,
   input  logic [7:0]        D_in,
   output logic [7:0]        D_out,
   output logic              D_oe,
   output logic              ram_req,
   output logic              ram_we,
   output logic [RAMA_W-1:0] ram_a,
   output logic [7:0]        ram_wd,
   input  logic [7:0]        ram_rd,
   input  logic              ram_ack
);

   logic w_phr;
   logic w_phf;
   logic w_ba;
   logic w_phf_eff;

   state_t r_state;
   state_t w_state_nxt;

   logic                r_dir;
   logic [15:0]         r_caddr;
   logic [RAMA_W-1:0]   r_raddr;
   logic [LEN_W-1:0]    r_cnt;
   logic [SETTLE_W-1:0] r_settle;

   logic       r_busy, r_done, r_ndma, r_nwedma, r_a_oe, r_d_oe, r_ram_req, r_ram_we;
   logic [7:0] r_d_out, r_ram_wd;
   logic       w_busy, w_done, w_ndma, w_nwedma, w_a_oe, w_d_oe, w_ram_req, w_ram_we;

   logic w_settle_last;
   logic w_cnt_last;

   reu_dma_phi2_sync u_sync (
      .i_clk  (C8M),
      .i_rst  (RESET),
      .i_phi2 (PHI2),
      .i_ba   (BA),
      .o_phr  (w_phr),
      .o_phf  (w_phf),
      .o_ba   (w_ba)
   );

   // A simultaneous rise/fall pair is a glitch and counts as a rising edge only
   assign w_phf_eff     = w_phf & ~w_phr;
   assign w_settle_last = (r_settle == SETTLE_W'(SETTLE_CYC - 1));
   assign w_cnt_last    = (r_cnt == LEN_W'(1));

   // State register
   always_ff @(posedge C8M or posedge RESET) begin
      if (RESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start) w_state_nxt = ST_ACQ;
         ST_ACQ:  if (w_phf_eff && w_settle_last)
                     w_state_nxt = (r_dir == DIR_FETCH) ? ST_PREF : ST_BUSW;
         ST_PREF: if (ram_ack) w_state_nxt = ST_BUSW;
         ST_BUSW: if (w_phr && w_ba) w_state_nxt = ST_BUSC;
         ST_BUSC: if (w_phf_eff) w_state_nxt = ST_BUSH;
         ST_BUSH: w_state_nxt = (r_dir == DIR_FETCH) ? ST_NEXT : ST_RAMW;
         ST_RAMW: if (ram_ack) w_state_nxt = ST_NEXT;
         ST_NEXT: begin
            if (w_cnt_last) w_state_nxt = ST_REL;
            else            w_state_nxt = (r_dir == DIR_FETCH) ? ST_PREF : ST_BUSW;
         end
         ST_REL:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output decode from the upcoming state so registered outputs line up with the state
   always_comb begin
      w_busy    = 1'b0;
      w_done    = 1'b0;
      w_ndma    = 1'b1;
      w_nwedma  = 1'b1;
      w_a_oe    = 1'b0;
      w_d_oe    = 1'b0;
      w_ram_req = 1'b0;
      w_ram_we  = 1'b0;
      w_busy    = is_busy_state(w_state_nxt);
      w_ndma    = ~w_busy;
      w_done    = (w_state_nxt == ST_REL);
      w_a_oe    = (w_state_nxt == ST_BUSC) || (w_state_nxt == ST_BUSH);
      w_d_oe    = w_a_oe && (r_dir == DIR_FETCH);
      w_nwedma  = ~w_d_oe;
      w_ram_req = (w_state_nxt == ST_PREF) || (w_state_nxt == ST_RAMW);
      w_ram_we  = (w_state_nxt == ST_RAMW);
   end

   // Output registers, transfer context and per-state datapath updates
   always_ff @(posedge C8M or posedge RESET) begin
      if (RESET) begin
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ndma    <= 1'b1;
         r_nwedma  <= 1'b1;
         r_a_oe    <= 1'b0;
         r_d_oe    <= 1'b0;
         r_ram_req <= 1'b0;
         r_ram_we  <= 1'b0;
         r_d_out   <= 8'h00;
         r_ram_wd  <= 8'h00;
         r_dir     <= DIR_STASH;
         r_caddr   <= 16'h0000;
         r_raddr   <= '0;
         r_cnt     <= '0;
         r_settle  <= '0;
      end else begin
         r_busy    <= w_busy;
         r_done    <= w_done;
         r_ndma    <= w_ndma;
         r_nwedma  <= w_nwedma;
         r_a_oe    <= w_a_oe;
         r_d_oe    <= w_d_oe;
         r_ram_req <= w_ram_req;
         r_ram_we  <= w_ram_we;
         case (r_state)
            ST_IDLE: if (start) begin
               r_dir    <= dir;
               r_caddr  <= c64_addr;
               r_raddr  <= ram_addr;
               r_cnt    <= len;
               r_settle <= '0;
            end
            ST_ACQ:  if (w_phf_eff) r_settle <= r_settle + SETTLE_W'(1);
            ST_PREF: if (ram_ack) r_d_out <= ram_rd;
            ST_BUSC: if (w_phf_eff && (r_dir == DIR_STASH)) r_ram_wd <= D_in;
            ST_NEXT: begin
               r_caddr <= r_caddr + 16'd1;
               r_raddr <= r_raddr + RAMA_W'(1);
               r_cnt   <= r_cnt - LEN_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign nDMA    = r_ndma;
   assign nWEDMA  = r_nwedma;
   assign A_out   = r_caddr;
   assign A_oe    = r_a_oe;
   assign D_out   = r_d_out;
   assign D_oe    = r_d_oe;
   assign ram_req = r_ram_req;
   assign ram_we  = r_ram_we;
   assign ram_a   = r_raddr;
   assign ram_wd  = r_ram_wd;

endmodule

// File: tb/tb_reu_dma.sv
// Bench for reu_dma: C64 memory and expansion-RAM models, transaction scoreboard, bus invariants.
module tb_reu_dma;

   localparam int unsigned RAMA_W   = 22;
   localparam int unsigned LEN_W    = 4;
   localparam int          RAM_MASK = 32'h003F_FFFF;

   logic              C8M = 1'b0;
   logic              RESET = 1'b1;
   logic              PHI2 = 1'b0;
   logic              BA = 1'b1;
   logic              start = 1'b0;
   logic              dir = 1'b0;
   logic [15:0]       c64_addr = 16'h0000;
   logic [RAMA_W-1:0] ram_addr = '0;
   logic [LEN_W-1:0]  len = '0;
   logic              busy, done, nDMA, nWEDMA, A_oe, D_oe, ram_req, ram_we;
   logic [15:0]       A_out;
   logic [7:0]        D_in, D_out, ram_wd;
   logic [RAMA_W-1:0] ram_a;
   logic [7:0]        ram_rd = 8'h00;
   logic              ram_ack = 1'b0;

   typedef struct {
      bit          is_c64;
      int unsigned addr;
      logic [7:0]  data;
   } ev_t;

   ev_t exp_q[$];
   ev_t obs_q[$];

   logic [7:0] c64_mem [0:65535];
   logic [7:0] ram_mem [int];

   int   total = 0;
   int   bad = 0;
   int   done_cnt = 0;
   int   byte_cnt = 0;
   int   ack_delay = 0;
   int   wait_cnt = 0;
   logic ba_next = 1'b1;
   logic cur_dir = 1'b0;

   logic             p_nwedma = 1'b1, p_a_oe = 1'b0, p_req = 1'b0, p_ndma = 1'b1, p_we = 1'b0;
   logic [RAMA_W-1:0] p_a = '0;
   logic [7:0]        p_wd = 8'h00;

   reu_dma #(.RAMA_W(RAMA_W), .LEN_W(LEN_W), .SETTLE_CYC(3)) dut (
      .C8M(C8M), .RESET(RESET), .PHI2(PHI2), .BA(BA),
      .start(start), .dir(dir), .c64_addr(c64_addr), .ram_addr(ram_addr), .len(len),
      .busy(busy), .done(done), .nDMA(nDMA), .nWEDMA(nWEDMA),
      .A_out(A_out), .A_oe(A_oe), .D_in(D_in), .D_out(D_out), .D_oe(D_oe),
      .ram_req(ram_req), .ram_we(ram_we), .ram_a(ram_a), .ram_wd(ram_wd),
      .ram_rd(ram_rd), .ram_ack(ram_ack)
   );

   always #5 C8M = ~C8M;

   // C64 memory answers reads whenever the DMA drives the address
   assign D_in = A_oe ? c64_mem[A_out] : 8'hFF;

   // PHI2 at 1/16 of C8M, offset from the C8M edges; BA changes late in the low phase
   initial begin
      #3;
      forever begin
         PHI2 = 1'b1; #80;
         PHI2 = 1'b0; #60;
         BA = ba_next; #20;
      end
   end

   function automatic logic [7:0] ram_peek(input int a);
      return ram_mem.exists(a) ? ram_mem[a] : 8'h00;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   // Expansion RAM controller model with programmable acknowledge latency
   initial begin
      forever begin
         @(negedge C8M);
         if (RESET) begin
            ram_ack  = 1'b0;
            wait_cnt = 0;
         end else if (ram_ack) begin
            ram_ack = 1'b0;
         end else if (ram_req) begin
            if (wait_cnt < ack_delay) begin
               wait_cnt++;
            end else begin
               wait_cnt = 0;
               if (ram_we) begin
                  ram_mem[int'(ram_a)] = ram_wd;
                  obs_q.push_back('{is_c64:1'b0, addr:32'(ram_a), data:ram_wd});
               end else begin
                  ram_rd = ram_peek(int'(ram_a));
               end
               ram_ack = 1'b1;
            end
         end
      end
   end

   // Per-cycle compare: scoreboard of byte moves plus port-protocol invariants
   always @(negedge C8M) begin
      ev_t o;
      ev_t e;
      if (!RESET) begin
         if (!nWEDMA && p_nwedma) begin
            c64_mem[A_out] = D_out;
            obs_q.push_back('{is_c64:1'b1, addr:32'(A_out), data:D_out});
         end
         while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected", o.addr, o.data);
            end else begin
               e = exp_q.pop_front();
               chk("write_side", 32'(o.is_c64), 32'(e.is_c64));
               chk("write_addr", o.addr, e.addr);
               chk("write_data", 32'(o.data), 32'(e.data));
               byte_cnt++;
            end
         end
         chk("busy_vs_ndma", 32'(busy), 32'(!nDMA));
         if (!nWEDMA) chk("wedma_in_bus_cycle", 32'(A_oe && D_oe), 32'd1);
         if (D_oe) begin
            chk("doe_with_aoe", 32'(A_oe), 32'd1);
            chk("doe_only_fetch", 32'(cur_dir), 32'd1);
         end
         if (A_oe) begin
            chk("aoe_while_busy", 32'(busy), 32'd1);
            chk("aoe_no_ram_req", 32'(ram_req), 32'd0);
         end
         if (A_oe && !p_a_oe) chk("bus_cycle_ba_high", 32'(BA), 32'd1);
         if (p_req && ram_req) begin
            chk("ram_a_stable", 32'(ram_a), 32'(p_a));
            chk("ram_we_stable", 32'(ram_we), 32'(p_we));
            chk("ram_wd_stable", 32'(ram_wd), 32'(p_wd));
         end
         if (nDMA && !p_ndma) begin
            chk("ndma_rise_all_moved", 32'(exp_q.size()), 32'd0);
            chk("ndma_rise_no_req", 32'(ram_req), 32'd0);
         end
         if (done) done_cnt++;
      end
      p_nwedma = nWEDMA;
      p_a_oe   = A_oe;
      p_req    = ram_req;
      p_ndma   = nDMA;
      p_a      = ram_a;
      p_we     = ram_we;
      p_wd     = ram_wd;
   end

   task automatic begin_xfer(input logic d, input logic [15:0] ca,
                             input logic [RAMA_W-1:0] ra, input logic [LEN_W-1:0] l);
      int n;
      n = (l == '0) ? (1 << LEN_W) : int'(l);
      exp_q.delete();
      done_cnt = 0;
      byte_cnt = 0;
      cur_dir  = d;
      for (int i = 0; i < n; i++) begin
         logic [15:0] ca_i;
         int          ra_i;
         ev_t         ev;
         ca_i = ca + 16'(i);
         ra_i = (int'(ra) + i) & RAM_MASK;
         if (d == 1'b0) ev = '{is_c64:1'b0, addr:32'(ra_i), data:c64_mem[ca_i]};
         else           ev = '{is_c64:1'b1, addr:32'(ca_i), data:ram_peek(ra_i)};
         exp_q.push_back(ev);
      end
      @(negedge C8M);
      dir = d; c64_addr = ca; ram_addr = ra; len = l; start = 1'b1;
      @(negedge C8M);
      start = 1'b0;
   endtask

   task automatic finish_xfer(input string tag, input int n);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge C8M);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: done not seen within 4000 cycles", tag);
      end
      repeat (4) @(negedge C8M);
      chk({tag, "_done_once"}, 32'(done_cnt), 32'd1);
      chk({tag, "_bytes"}, 32'(byte_cnt), 32'(n));
      chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
      chk({tag, "_ndma_after"}, 32'(nDMA), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      for (int i = 0; i < 65536; i++) c64_mem[i] = 8'h00;

      repeat (3) @(negedge C8M);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ndma", 32'(nDMA), 32'd1);
      chk("rst_nwedma", 32'(nWEDMA), 32'd1);
      chk("rst_a_oe", 32'(A_oe), 32'd0);
      chk("rst_d_oe", 32'(D_oe), 32'd0);
      chk("rst_ram_req", 32'(ram_req), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_a_out", 32'(A_out), 32'd0);
      chk("rst_d_out", 32'(D_out), 32'd0);
      chk("rst_ram_a", 32'(ram_a), 32'd0);
      chk("rst_ram_wd", 32'(ram_wd), 32'd0);
      RESET = 1'b0;
      repeat (2) @(negedge C8M);

      // Stash three bytes from $C000; a second start while busy must be ignored
      c64_mem[16'hC000] = 8'h11;
      c64_mem[16'hC001] = 8'h22;
      c64_mem[16'hC002] = 8'h33;
      begin_xfer(1'b0, 16'hC000, 22'h000000, 4'd3);
      repeat (30) @(negedge C8M);
      chk("busy_mid_stash", 32'(busy), 32'd1);
      dir = 1'b1; c64_addr = 16'h5555; ram_addr = 22'h000100; len = 4'd1; start = 1'b1;
      @(negedge C8M);
      start = 1'b0;
      finish_xfer("stash", 3);
      chk("stash_ram0", 32'(ram_peek(0)), 32'h11);
      chk("stash_ram1", 32'(ram_peek(1)), 32'h22);
      chk("stash_ram2", 32'(ram_peek(2)), 32'h33);

      // Fetch across both address wraps
      ram_mem[32'h003F_FFFF] = 8'hAA;
      ram_mem[0] = 8'hBB;
      begin_xfer(1'b1, 16'hFFFF, 22'h3FFFFF, 4'd2);
      finish_xfer("fetch", 2);
      chk("fetch_c64_ffff", 32'(c64_mem[16'hFFFF]), 32'hAA);
      chk("fetch_c64_0000", 32'(c64_mem[16'h0000]), 32'hBB);

      // VIC holds BA low for two PHI2 cycles mid-stash
      for (int i = 0; i < 6; i++) c64_mem[16'h1000 + 16'(i)] = 8'hA0 + 8'(i);
      begin_xfer(1'b0, 16'h1000, 22'h001000, 4'd6);
      repeat (5) @(posedge PHI2);
      ba_next = 1'b0;
      repeat (2) @(posedge PHI2);
      ba_next = 1'b1;
      finish_xfer("ba_stall", 6);
      chk("ba_stall_last", 32'(ram_peek(32'h1005)), 32'hA5);

      // Slow RAM acknowledge during a fetch
      ram_mem[32'h2000] = 8'h5A;
      ram_mem[32'h2001] = 8'h5B;
      ram_mem[32'h2002] = 8'h5C;
      ack_delay = 20;
      begin_xfer(1'b1, 16'h3000, 22'h002000, 4'd3);
      finish_xfer("slow_ack", 3);
      ack_delay = 0;
      chk("slow_ack_c64_3002", 32'(c64_mem[16'h3002]), 32'h5C);

      // Reset while the first fetch bus cycle is being driven
      ram_mem[32'h2100] = 8'h71;
      ram_mem[32'h2101] = 8'h72;
      ram_mem[32'h2102] = 8'h73;
      begin_xfer(1'b1, 16'h6000, 22'h002100, 4'd3);
      seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge C8M);
         if (!nWEDMA) begin
            seen = 1'b1;
            break;
         end
      end
      chk("rst_test_reached_busc", 32'(seen), 32'd1);
      #2;
      RESET = 1'b1;
      #1;
      chk("async_rst_ndma", 32'(nDMA), 32'd1);
      chk("async_rst_nwedma", 32'(nWEDMA), 32'd1);
      chk("async_rst_ram_req", 32'(ram_req), 32'd0);
      chk("async_rst_a_oe", 32'(A_oe), 32'd0);
      chk("async_rst_d_oe", 32'(D_oe), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge C8M);
      exp_q.delete();
      obs_q.delete();
      RESET = 1'b0;
      repeat (2) @(negedge C8M);

      // len=0 with a 4-bit count moves 16 bytes; RAM address wraps past the top
      for (int i = 0; i < 16; i++) c64_mem[16'h4000 + 16'(i)] = 8'(i * 7 + 1);
      begin_xfer(1'b0, 16'h4000, 22'h3FFFF8, 4'd0);
      finish_xfer("len0", 16);
      chk("len0_ram_top", 32'(ram_peek(32'h003F_FFFF)), 32'h32);
      chk("len0_ram_wrap", 32'(ram_peek(32'h7)), 32'h6A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
